// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction game and its score stage.
// Winner codes and FSM states used across the slice.
package reaction_pkg;

  typedef enum logic {
    PLAY,
    OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEF_WIN_SCORE   = 3;
  localparam int DEF_HOLD_CYCLES = 5;

endpackage

// File: rtl/match_score_keeper_if.sv
// Lamp inputs and score/result outputs of the match score stage.
// master = game/observer side, slave = score keeper.
interface match_score_keeper_if #(
  parameter int SCORE_W = 4
);

  logic               win1_led;
  logic               win2_led;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [7:0]         round_cnt;
  logic               match_over;
  logic [1:0]         match_winner;

  modport master (
    output win1_led,
    output win2_led,
    input  score1,
    input  score2,
    input  round_cnt,
    input  match_over,
    input  match_winner
  );

  modport slave (
    input  win1_led,
    input  win2_led,
    output score1,
    output score2,
    output round_cnt,
    output match_over,
    output match_winner
  );

endinterface

// File: rtl/match_score_keeper_rise_detect.sv
// One-bit rising-edge detector; previous value is registered.
// rise is high in the first cycle the input is seen high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/match_score_keeper.sv
// Match score keeper: counts round wins per player, declares a winner,
// holds the result for HOLD_CYCLES cycles, then clears for the next match.
module match_score_keeper
  import reaction_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = 4,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input logic clk,
  input logic reset,
  match_score_keeper_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t             state;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [7:0]         round_cnt;
  logic               match_over;
  logic [1:0]         match_winner;
  logic [HW-1:0]      hold_cnt;

  logic               r1;
  logic               r2;
  logic [SCORE_W-1:0] s1_inc;
  logic [SCORE_W-1:0] s2_inc;
  logic [7:0]         rc_inc;

  rise_detect u_rise1 (
    .clk  (clk),
    .reset(reset),
    .d    (bus.win1_led),
    .rise (r1)
  );

  rise_detect u_rise2 (
    .clk  (clk),
    .reset(reset),
    .d    (bus.win2_led),
    .rise (r2)
  );

  assign s1_inc = score1 + SCORE_W'(1);
  assign s2_inc = score2 + SCORE_W'(1);
  assign rc_inc = (round_cnt == 8'hFF) ? round_cnt : round_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PLAY;
      score1       <= '0;
      score2       <= '0;
      round_cnt    <= '0;
      match_over   <= 1'b0;
      match_winner <= WIN_NONE;
      hold_cnt     <= '0;
    end else begin
      unique case (state)
        PLAY: begin
          if (r1 || r2) round_cnt <= rc_inc;
          // a simultaneous rise is a tied round: counted, nobody scores
          if (r1 && !r2) begin
            score1 <= s1_inc;
            if (s1_inc == WIN_V) begin
              state        <= OVER;
              match_over   <= 1'b1;
              match_winner <= WIN_P1;
              hold_cnt     <= '0;
            end
          end
          if (r2 && !r1) begin
            score2 <= s2_inc;
            if (s2_inc == WIN_V) begin
              state        <= OVER;
              match_over   <= 1'b1;
              match_winner <= WIN_P2;
              hold_cnt     <= '0;
            end
          end
        end
        OVER: begin
          if (hold_cnt == HOLD_LAST) begin
            state        <= PLAY;
            score1       <= '0;
            score2       <= '0;
            round_cnt    <= '0;
            match_over   <= 1'b0;
            match_winner <= WIN_NONE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
      endcase
    end
  end

  assign bus.score1       = score1;
  assign bus.score2       = score2;
  assign bus.round_cnt    = round_cnt;
  assign bus.match_over   = match_over;
  assign bus.match_winner = match_winner;

endmodule

// File: tb/tb_match_score_keeper.sv
// Directed bench for match_score_keeper: default build plus a
// WIN_SCORE=1 / HOLD_CYCLES=1 corner build sharing clock and reset.
module tb_match_score_keeper;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  match_score_keeper_if #(.SCORE_W(4)) bus ();
  match_score_keeper_if #(.SCORE_W(4)) cbus ();

  match_score_keeper #(
    .WIN_SCORE  (3),
    .SCORE_W    (4),
    .HOLD_CYCLES(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  match_score_keeper #(
    .WIN_SCORE  (1),
    .SCORE_W    (4),
    .HOLD_CYCLES(1)
  ) dut_c (
    .clk  (clk),
    .reset(reset),
    .bus  (cbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(string tag, int s1, int s2, int rc, int ov, int wn);
    chk({tag, ".score1"}, 8'(bus.score1), 8'(s1));
    chk({tag, ".score2"}, 8'(bus.score2), 8'(s2));
    chk({tag, ".round_cnt"}, bus.round_cnt, 8'(rc));
    chk({tag, ".match_over"}, 8'(bus.match_over), 8'(ov));
    chk({tag, ".match_winner"}, 8'(bus.match_winner), 8'(wn));
  endtask

  task automatic chk_c(string tag, int s1, int s2, int rc, int ov, int wn);
    chk({tag, ".score1"}, 8'(cbus.score1), 8'(s1));
    chk({tag, ".score2"}, 8'(cbus.score2), 8'(s2));
    chk({tag, ".round_cnt"}, cbus.round_cnt, 8'(rc));
    chk({tag, ".match_over"}, 8'(cbus.match_over), 8'(ov));
    chk({tag, ".match_winner"}, 8'(cbus.match_winner), 8'(wn));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.win1_led  = 1'b0;
    bus.win2_led  = 1'b0;
    cbus.win1_led = 1'b0;
    cbus.win2_led = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_m("reset", 0, 0, 0, 0, 0);
    chk_c("reset_c", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // three separate 3-cycle pulses of win1_led
    for (int p = 1; p <= 3; p++) begin
      bus.win1_led = 1'b1;
      tick();
      chk_m($sformatf("p1_rise%0d", p), 0 + p, 0, p,
            (p == 3) ? 1 : 0, (p == 3) ? 1 : 0);
      tick();
      tick();
      bus.win1_led = 1'b0;
      tick();
    end
    chk_m("p1_hold", 3, 0, 3, 1, 1);

    // asynchronous reset in the middle of the hold
    #2 reset = 1'b1;
    #1;
    chk_m("reset_async", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    bus.win1_led = 1'b1;
    tick();
    chk_m("post_reset", 1, 0, 1, 0, 0);
    bus.win1_led = 1'b0;
    tick();
    reset = 1'b1;
    #2 reset = 1'b0;

    // held lamp counts once
    bus.win2_led = 1'b1;
    repeat (20) tick();
    chk_m("held2", 0, 1, 1, 0, 0);
    bus.win2_led = 1'b0;
    tick();

    // tie
    bus.win1_led = 1'b1;
    bus.win2_led = 1'b1;
    tick();
    chk_m("tie", 0, 1, 2, 0, 0);
    bus.win1_led = 1'b0;
    bus.win2_led = 1'b0;
    tick();

    // P2 win, hold, auto-clear
    bus.win2_led = 1'b1;
    tick();
    chk_m("p2_2", 0, 2, 3, 0, 0);
    bus.win2_led = 1'b0;
    tick();
    bus.win2_led = 1'b1;
    tick();
    chk_m("p2_win", 0, 3, 4, 1, 2);
    bus.win2_led = 1'b0;
    bus.win1_led = 1'b1;
    tick();
    chk_m("hold1", 0, 3, 4, 1, 2);
    bus.win1_led = 1'b0;
    tick();
    chk_m("hold2", 0, 3, 4, 1, 2);
    tick();
    chk_m("hold3", 0, 3, 4, 1, 2);
    tick();
    chk_m("hold4", 0, 3, 4, 1, 2);
    bus.win1_led = 1'b1;
    tick();
    chk_m("clear", 0, 0, 0, 0, 0);
    bus.win2_led = 1'b1;
    tick();
    chk_m("after_clear", 0, 1, 1, 0, 0);
    bus.win1_led = 1'b0;
    bus.win2_led = 1'b0;
    tick();

    // corner build: one point wins, one-cycle hold
    cbus.win1_led = 1'b1;
    tick();
    chk_c("c_win", 1, 0, 1, 1, 1);
    tick();
    chk_c("c_clear", 0, 0, 0, 0, 0);
    cbus.win1_led = 1'b0;
    tick();
    cbus.win2_led = 1'b1;
    tick();
    chk_c("c_p2", 0, 1, 1, 1, 2);
    cbus.win2_led = 1'b0;
    tick();
    chk_c("c_clear2", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_score_keeper.md
# match_score_keeper

Score stage directly downstream of the reaction game. It consumes the game's per-round winner lamps (`win1_led`, `win2_led`), counts points per player and declares a match winner once a player reaches `WIN_SCORE`. It holds the result for `HOLD_CYCLES`, then clears the match and waits for the next one. All inputs come from the same `clk` domain as the game, so there is no input synchronizer.

## Interface
- `WIN_SCORE`, default 3: points needed to win a match; legal range 1 ≤ `WIN_SCORE` < 2**`SCORE_W`.
- `SCORE_W`, default 4: width of each score counter.
- `HOLD_CYCLES`, default 5: cycles the match result is held before auto-clear; must be ≥ 1.

Ports:
- `clk` in 1: system clock. Reset is `reset`, asynchronous, active-high; the clock is `clk`.
- `reset` in 1: asynchronous, active-high; clears all state.
- `win1_led` in 1: player-1 round-win lamp from the game stage (registered, level).
- `win2_led` in 1: player-2 round-win lamp from the game stage (registered, level).
- `score1` out `SCORE_W`: player-1 points in the current match.
- `score2` out `SCORE_W`: player-2 points in the current match.
- `round_cnt` out 8: rounds counted in the current match, saturating at 255.
- `match_over` out 1: high while the result is held.
- `match_winner` out 2: 2'b01 = player 1, 2'b10 = player 2, 2'b00 = none.

## Operation
- **Reset values:** all outputs 0. The previous-value registers of both lamps are 0. State is PLAY. The hold counter is 0.
- **Edge detect:**
  - `r1` = `win1_led` & ~`win1_prev`; `r2` = `win2_led` & ~`win2_prev`.
  - The prev registers update every cycle in every state.
  - A lamp held high across the OVER→PLAY transition therefore never scores twice.
- **State PLAY:**
  - `r1` only: `score1`+1, `round_cnt`+1 (saturating).
  - `r2` only: `score2`+1, `round_cnt`+1.
  - `r1` & `r2` together: tie. `round_cnt`+1, no score change.
  - If the incremented score equals `WIN_SCORE`, in the same cycle: go to OVER, set `match_over`=1, set `match_winner` to that player, load hold counter = 0.
- **State OVER:**
  - Scores and `round_cnt` are frozen; `r1`/`r2` are ignored.
  - The hold counter increments each cycle.
  - When the hold counter reaches `HOLD_CYCLES`-1, on the next edge: `score1`, `score2` and `round_cnt` go to 0, `match_winner`=0, `match_over`=0, state goes to PLAY.
- **Width rules:** scores never exceed `WIN_SCORE`, so no wrap is possible. The hold counter is $clog2(`HOLD_CYCLES`+1) bits. `round_cnt` saturates at 255 and does not wrap.
- **Reset mid-match or mid-hold:** immediate return to reset values; no partial result survives.

## Timing
- Scoring latency is 1 cycle. If `win1_led` first samples high at edge k (prev=0), `score1` and `round_cnt` show the new value after edge k.
- The winning point, `match_over` and `match_winner` all become visible after the same edge.
- `match_over` stays high for exactly `HOLD_CYCLES` cycles.
- A lamp rise sampled on the clearing edge is ignored.
- A lamp rise sampled one edge after clearing is counted.
- The block has no handshake and no backpressure. It is a pure observer of the game stage.

## Structure
- **Shared package `reaction_pkg`:**
  - state typedef `enum {PLAY, OVER}`
  - winner encoding constants `WIN_NONE`=2'b00, `WIN_P1`=2'b01, `WIN_P2`=2'b10
  - default `WIN_SCORE` / `HOLD_CYCLES` constants shared with the game stage
- **Sub-module `rise_detect`:** 1-bit registered rising-edge detector with asynchronous reset. Instantiate it twice, one per lamp.
- **Top module:** the FSM, score counters, round counter and hold counter.

## Test plan
1. **Basic P1 win.** Defaults; pulse `win1_led` high for 3 cycles, three separate times (low in between) → `score1` steps 1,2,3; after the third rise `match_over`=1, `match_winner`=01, `round_cnt`=3.
2. **Held lamp counts once.** Hold `win2_led` high for 20 cycles → `score2`=1 exactly, `round_cnt`=1.
3. **Tie.** `win1_led` and `win2_led` rise on the same edge → `round_cnt`+1, both scores unchanged.
4. **Hold and auto-clear.** After a P2 win, count cycles → `match_over` is high for exactly 5 cycles. On clear, all outputs are 0. A rise inside the hold is ignored. A rise one cycle after clear gives `score`=1.
5. **Reset mid-hold.** Assert `reset` during OVER → all outputs 0 immediately (asynchronous). After release, a new rise scores 1.
6. **Parameter corner.** `WIN_SCORE`=1, `HOLD_CYCLES`=1 → the first rise ends the match; `match_over` is high for one cycle; `round_cnt`=1 then 0.
